// File: rtl/ccu_snoop_fanout_merge.sv
// Snoop fan-out/merge: broadcasts one AC to the masked masters, merges their
// CR responses into one upstream CR, forwards one CD burst and drains the rest.
// Ports:
//   upstream ac_*/cr_*/cd_*          : one snoop from the snoop FSMs
//   mst_ac_*/mst_cr_*/mst_cd_*       : per-master snoop channels (bit/slice i)
module ccu_snoop_fanout_merge #(
    parameter int unsigned NumMst    = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        ac_valid_i,
    output logic                        ac_ready_o,
    input  logic [AddrWidth-1:0]        ac_addr_i,
    input  logic [3:0]                  ac_snoop_i,
    input  logic [2:0]                  ac_prot_i,
    input  logic [NumMst-1:0]           domain_mask_i,
    output logic                        cr_valid_o,
    input  logic                        cr_ready_i,
    output logic [4:0]                  cr_resp_o,
    output logic                        cd_valid_o,
    input  logic                        cd_ready_i,
    output logic [DataWidth-1:0]        cd_data_o,
    output logic                        cd_last_o,
    output logic [NumMst-1:0]           mst_ac_valid_o,
    input  logic [NumMst-1:0]           mst_ac_ready_i,
    output logic [AddrWidth-1:0]        mst_ac_addr_o,
    output logic [3:0]                  mst_ac_snoop_o,
    output logic [2:0]                  mst_ac_prot_o,
    input  logic [NumMst-1:0]           mst_cr_valid_i,
    output logic [NumMst-1:0]           mst_cr_ready_o,
    input  logic [5*NumMst-1:0]         mst_cr_resp_i,
    input  logic [NumMst-1:0]           mst_cd_valid_i,
    output logic [NumMst-1:0]           mst_cd_ready_o,
    input  logic [DataWidth*NumMst-1:0] mst_cd_data_i,
    input  logic [NumMst-1:0]           mst_cd_last_i
);
    localparam int unsigned SrcW = (NumMst > 1) ? $clog2(NumMst) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        RESP  = 2'd2,
        DATA  = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [AddrWidth-1:0]  r_addr;
    logic [3:0]            r_snoop;
    logic [2:0]            r_prot;
    logic [NumMst-1:0]     r_mask;
    logic [NumMst-1:0]     r_ac_done;
    logic [NumMst-1:0]     r_cr_done;
    logic [NumMst-1:0]     r_dt_vec;
    logic [NumMst-1:0]     r_pd_vec;
    logic [NumMst-1:0]     r_drain_done;
    logic [4:0]            r_resp;
    logic [SrcW-1:0]       r_src;

    logic                  w_ac_hs;
    logic                  w_in_data;
    logic [NumMst-1:0]     w_ac_hs_m;
    logic [NumMst-1:0]     w_cr_hs_m;
    logic [NumMst-1:0]     w_cd_hs_m;
    logic [NumMst-1:0]     w_drain_set;
    logic [NumMst-1:0]     w_cr_dt;
    logic [NumMst-1:0]     w_cr_pd;
    logic [NumMst-1:0]     w_dt_nxt;
    logic [NumMst-1:0]     w_pd_nxt;
    logic [NumMst-1:0]     w_dirty_src;
    logic [NumMst-1:0]     w_src_oh;
    logic [4:0]            w_cr_or;
    logic [4:0]            w_resp_nxt;
    logic [SrcW-1:0]       w_src_sel;
    logic                  w_src_valid;
    logic                  w_src_last;
    logic                  w_src_open;
    logic [DataWidth-1:0]  w_src_data;

    assign w_ac_hs     = ac_valid_i & ac_ready_o;
    assign w_ac_hs_m   = mst_ac_valid_o & mst_ac_ready_i;
    assign w_cr_hs_m   = mst_cr_valid_i & mst_cr_ready_o;
    assign w_cd_hs_m   = mst_cd_valid_i & mst_cd_ready_o;
    assign w_drain_set = w_cd_hs_m & mst_cd_last_i;
    assign w_in_data   = (r_state == DATA);

    always_comb begin
        w_cr_or = '0;
        w_cr_dt = '0;
        w_cr_pd = '0;
        for (int i = 0; i < NumMst; i++) begin
            if (w_cr_hs_m[i]) w_cr_or = w_cr_or | mst_cr_resp_i[5*i +: 5];
            w_cr_dt[i] = mst_cr_resp_i[5*i];
            w_cr_pd[i] = mst_cr_resp_i[5*i+2];
        end
    end

    assign w_dt_nxt    = r_dt_vec | (w_cr_hs_m & w_cr_dt);
    assign w_pd_nxt    = r_pd_vec | (w_cr_hs_m & w_cr_pd);
    assign w_dirty_src = w_dt_nxt & w_pd_nxt;
    // PassDirty is not OR-merged: it comes only from the chosen dirty source.
    assign w_resp_nxt  = ((r_resp | w_cr_or) & 5'b11011)
                       | {2'b00, |w_dirty_src, 2'b00};

    // Lowest dirty data source wins; otherwise lowest plain data source.
    always_comb begin
        w_src_sel = '0;
        for (int i = NumMst - 1; i >= 0; i--) begin
            if (w_dt_nxt[i]) w_src_sel = SrcW'(i);
        end
        for (int i = NumMst - 1; i >= 0; i--) begin
            if (w_dirty_src[i]) w_src_sel = SrcW'(i);
        end
    end

    always_comb begin
        w_src_oh    = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_data  = '0;
        for (int i = 0; i < NumMst; i++) begin
            if (r_src == SrcW'(i)) begin
                w_src_oh[i] = 1'b1;
                w_src_valid = mst_cd_valid_i[i];
                w_src_last  = mst_cd_last_i[i];
                w_src_data  = mst_cd_data_i[DataWidth*i +: DataWidth];
            end
        end
    end

    assign w_src_open = |(w_src_oh & ~r_drain_done);

    assign ac_ready_o     = (r_state == IDLE);
    assign mst_ac_valid_o = (r_state == SNOOP) ? (r_mask & ~r_ac_done) : '0;
    assign mst_cr_ready_o = (r_state == SNOOP)
                          ? (r_mask & r_ac_done & ~r_cr_done) : '0;
    assign mst_ac_addr_o  = r_addr;
    assign mst_ac_snoop_o = r_snoop;
    assign mst_ac_prot_o  = r_prot;
    assign cr_valid_o     = (r_state == RESP);
    assign cr_resp_o      = r_resp;
    assign cd_valid_o     = w_in_data & w_src_valid & w_src_open;
    assign cd_last_o      = w_in_data & w_src_last;
    assign cd_data_o      = w_in_data ? w_src_data : '0;
    // Source follows upstream ready; other data holders are drained freely.
    assign mst_cd_ready_o = w_in_data
                          ? (((w_src_oh & {NumMst{cd_ready_i}})
                             | ~w_src_oh) & r_dt_vec & ~r_drain_done)
                          : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_ac_hs) w_state_nxt = (|domain_mask_i) ? SNOOP : RESP;
            end
            SNOOP: begin
                if ((r_cr_done | w_cr_hs_m) == r_mask) w_state_nxt = RESP;
            end
            RESP: begin
                if (cr_ready_i) w_state_nxt = r_resp[0] ? DATA : IDLE;
            end
            DATA: begin
                if ((r_drain_done | w_drain_set) == r_dt_vec) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_snoop      <= '0;
            r_prot       <= '0;
            r_mask       <= '0;
            r_ac_done    <= '0;
            r_cr_done    <= '0;
            r_dt_vec     <= '0;
            r_pd_vec     <= '0;
            r_drain_done <= '0;
            r_resp       <= '0;
            r_src        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_ac_hs) begin
                        r_addr       <= ac_addr_i;
                        r_snoop      <= ac_snoop_i;
                        r_prot       <= ac_prot_i;
                        r_mask       <= domain_mask_i;
                        r_ac_done    <= '0;
                        r_cr_done    <= '0;
                        r_dt_vec     <= '0;
                        r_pd_vec     <= '0;
                        r_drain_done <= '0;
                        r_resp       <= '0;
                        r_src        <= '0;
                    end
                end
                SNOOP: begin
                    r_ac_done <= r_ac_done | w_ac_hs_m;
                    r_cr_done <= r_cr_done | w_cr_hs_m;
                    r_dt_vec  <= w_dt_nxt;
                    r_pd_vec  <= w_pd_nxt;
                    r_resp    <= w_resp_nxt;
                    r_src     <= w_src_sel;
                end
                DATA: begin
                    r_drain_done <= r_drain_done | w_drain_set;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ccu_snoop_fanout_merge.sv
// Directed bench for ccu_snoop_fanout_merge with behavioural snooped masters.
// Inputs change on the falling edge; handshakes are judged just after it.
module tb_ccu_snoop_fanout_merge;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            ac_valid_i = 1'b0;
    logic            ac_ready_o;
    logic [AW-1:0]   ac_addr_i = '0;
    logic [3:0]      ac_snoop_i = '0;
    logic [2:0]      ac_prot_i = '0;
    logic [N-1:0]    domain_mask_i = '0;
    logic            cr_valid_o;
    logic            cr_ready_i = 1'b0;
    logic [4:0]      cr_resp_o;
    logic            cd_valid_o;
    logic            cd_ready_i = 1'b0;
    logic [DW-1:0]   cd_data_o;
    logic            cd_last_o;
    logic [N-1:0]    mst_ac_valid_o;
    logic [N-1:0]    mst_ac_ready_i = '0;
    logic [AW-1:0]   mst_ac_addr_o;
    logic [3:0]      mst_ac_snoop_o;
    logic [2:0]      mst_ac_prot_o;
    logic [N-1:0]    mst_cr_valid_i = '0;
    logic [N-1:0]    mst_cr_ready_o;
    logic [5*N-1:0]  mst_cr_resp_i = '0;
    logic [N-1:0]    mst_cd_valid_i = '0;
    logic [N-1:0]    mst_cd_ready_o;
    logic [DW*N-1:0] mst_cd_data_i = '0;
    logic [N-1:0]    mst_cd_last_i = '0;

    ccu_snoop_fanout_merge #(
        .NumMst   (N),
        .AddrWidth(AW),
        .DataWidth(DW)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ac_valid_i    (ac_valid_i),
        .ac_ready_o    (ac_ready_o),
        .ac_addr_i     (ac_addr_i),
        .ac_snoop_i    (ac_snoop_i),
        .ac_prot_i     (ac_prot_i),
        .domain_mask_i (domain_mask_i),
        .cr_valid_o    (cr_valid_o),
        .cr_ready_i    (cr_ready_i),
        .cr_resp_o     (cr_resp_o),
        .cd_valid_o    (cd_valid_o),
        .cd_ready_i    (cd_ready_i),
        .cd_data_o     (cd_data_o),
        .cd_last_o     (cd_last_o),
        .mst_ac_valid_o(mst_ac_valid_o),
        .mst_ac_ready_i(mst_ac_ready_i),
        .mst_ac_addr_o (mst_ac_addr_o),
        .mst_ac_snoop_o(mst_ac_snoop_o),
        .mst_ac_prot_o (mst_ac_prot_o),
        .mst_cr_valid_i(mst_cr_valid_i),
        .mst_cr_ready_o(mst_cr_ready_o),
        .mst_cr_resp_i (mst_cr_resp_i),
        .mst_cd_valid_i(mst_cd_valid_i),
        .mst_cd_ready_o(mst_cd_ready_o),
        .mst_cd_data_i (mst_cd_data_i),
        .mst_cd_last_i (mst_cd_last_i)
    );

    always #5 clk_i = ~clk_i;

    int          errs;
    int          checks;

    int          cfg_ac_dly [N];
    logic [4:0]  cfg_resp   [N];
    int          cfg_len    [N];
    logic [63:0] cfg_base   [N];
    bit          cfg_cr_rdy;
    bit          cfg_cd_tog;

    int          m_acv  [N];
    int          ac_cnt [N];
    int          cr_cnt [N];
    int          m_beat [N];
    bit          cr_pend[N];
    bit          cd_pend[N];

    int          up_cr_n;
    logic [4:0]  up_cr;
    logic [N-1:0] cr_seen;
    bit          cr_v_prev;
    int          up_n;
    logic [63:0] up_data[16];
    logic [15:0] up_last;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic setm(input int i, input int dly, input logic [4:0] resp,
                        input int len, input logic [63:0] base);
        cfg_ac_dly[i] = dly;
        cfg_resp[i]   = resp;
        cfg_len[i]    = len;
        cfg_base[i]   = base;
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            ac_cnt[i] = 0;
            cr_cnt[i] = 0;
        end
        up_cr_n = 0;
        up_cr   = '0;
        up_n    = 0;
        up_last = '0;
        cr_seen = '0;
    endtask

    // Returns one cycle after the upstream AC handshake.
    task automatic send_ac(input logic [63:0] a, input logic [3:0] s,
                           input logic [2:0] p, input logic [N-1:0] m);
        int n;
        ac_addr_i     = a;
        ac_snoop_i    = s;
        ac_prot_i     = p;
        domain_mask_i = m;
        ac_valid_i    = 1'b1;
        n = 0;
        while (!ac_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("ac_accept", 64'(ac_ready_o), 64'd1);
        tick();
        ac_valid_i = 1'b0;
    endtask

    task automatic wait_cr(input int n0);
        int n;
        n = 0;
        while (up_cr_n == n0 && n < 200) begin
            tick();
            n++;
        end
        chk("cr_arrive", 64'(up_cr_n), 64'(n0 + 1));
    endtask

    task automatic wait_data(input int beats);
        int n;
        n = 0;
        while (!(up_n >= beats && ac_ready_o) && n < 200) begin
            tick();
            n++;
        end
        chk("cd_beats", 64'(up_n), 64'(beats));
        chk("cd_idle", 64'(ac_ready_o), 64'd1);
    endtask

    // Behavioural snooped masters plus upstream CR/CD sinks.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                for (int i = 0; i < N; i++) begin
                    m_acv[i]   = 0;
                    cr_pend[i] = 1'b0;
                    cd_pend[i] = 1'b0;
                end
                mst_ac_ready_i = '0;
                mst_cr_valid_i = '0;
                mst_cd_valid_i = '0;
                mst_cd_last_i  = '0;
                cr_ready_i     = 1'b0;
                cd_ready_i     = 1'b0;
                cr_v_prev      = 1'b0;
            end else begin
                cr_ready_i = cfg_cr_rdy;
                cd_ready_i = cfg_cd_tog ? ~cd_ready_i : 1'b1;
                for (int i = 0; i < N; i++) begin
                    mst_ac_ready_i[i] = (m_acv[i] >= cfg_ac_dly[i]);
                    mst_cr_valid_i[i] = cr_pend[i];
                    mst_cr_resp_i[5*i +: 5] = cfg_resp[i];
                    mst_cd_valid_i[i] = cd_pend[i];
                    mst_cd_data_i[DW*i +: DW] = cfg_base[i] + 64'(m_beat[i]);
                    mst_cd_last_i[i] = cd_pend[i]
                                     && (m_beat[i] == cfg_len[i] - 1);
                end
                #1;
                if (cr_valid_o && !cr_v_prev) begin
                    for (int i = 0; i < N; i++) cr_seen[i] = (cr_cnt[i] != 0);
                end
                cr_v_prev = cr_valid_o;
                if (cr_valid_o && cr_ready_i) begin
                    up_cr = cr_resp_o;
                    up_cr_n++;
                end
                if (cd_valid_o && cd_ready_i) begin
                    if (up_n < 16) begin
                        up_data[up_n] = cd_data_o;
                        up_last[up_n] = cd_last_o;
                    end
                    up_n++;
                end
                for (int i = 0; i < N; i++) begin
                    if (mst_cd_valid_i[i] && mst_cd_ready_o[i]) begin
                        if (mst_cd_last_i[i]) cd_pend[i] = 1'b0;
                        m_beat[i]++;
                    end
                    if (mst_cr_valid_i[i] && mst_cr_ready_o[i]) begin
                        cr_pend[i] = 1'b0;
                        cr_cnt[i]++;
                        if (cfg_resp[i][0]) begin
                            cd_pend[i] = 1'b1;
                            m_beat[i]  = 0;
                        end
                    end
                    if (mst_ac_valid_o[i] && mst_ac_ready_i[i]) begin
                        ac_cnt[i]++;
                        cr_pend[i] = 1'b1;
                        m_acv[i]   = 0;
                    end else if (mst_ac_valid_o[i]) begin
                        m_acv[i]++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        errs       = 0;
        checks     = 0;
        cfg_cr_rdy = 1'b0;
        cfg_cd_tog = 1'b0;
        for (int i = 0; i < N; i++) begin
            setm(i, 0, 5'b0, 0, 64'h0);
            m_beat[i] = 0;
        end
        clr();
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("rst_valids", 64'({cr_valid_o, cd_valid_o, mst_ac_valid_o,
                               mst_cr_ready_o, mst_cd_ready_o}), 64'd0);
        chk("rst_cr_resp", 64'(cr_resp_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Empty mask: immediate zero response.
        clr();
        send_ac(64'h1000, 4'h1, 3'h0, 4'b0000);
        chk("t1_cr_valid", 64'(cr_valid_o), 64'd1);
        chk("t1_cr_resp", 64'(cr_resp_o), 64'd0);
        chk("t1_no_ac", 64'(mst_ac_valid_o), 64'd0);
        chk("t1_busy", 64'(ac_ready_o), 64'd0);
        cfg_cr_rdy = 1'b1;
        wait_cr(0);
        chk("t1_idle", 64'(ac_ready_o), 64'd1);

        // Two masters, one slow on AC, both clean.
        setm(1, 0, 5'b0, 0, 64'h0);
        setm(2, 3, 5'b0, 0, 64'h0);
        clr();
        send_ac(64'h2000, 4'h2, 3'h1, 4'b0110);
        wait_cr(0);
        chk("t2_resp", 64'(up_cr), 64'd0);
        chk("t2_ac1", 64'(ac_cnt[1]), 64'd1);
        chk("t2_ac2", 64'(ac_cnt[2]), 64'd1);
        chk("t2_ac_others", 64'(ac_cnt[0] + ac_cnt[3]), 64'd0);
        chk("t2_cr_before", 64'(cr_seen), 64'b0110);
        chk("t2_no_cd", 64'(up_n), 64'd0);
        chk("t2_idle", 64'(ac_ready_o), 64'd1);

        // All four: dirty source 3 wins, source 1 drained.
        setm(0, 0, 5'b00000, 0, 64'h0);
        setm(1, 0, 5'b01001, 4, 64'hA100);
        setm(2, 0, 5'b00000, 0, 64'h0);
        setm(3, 1, 5'b00101, 4, 64'hB300);
        clr();
        send_ac(64'hDEAD_BEEF_0000_1240, 4'b0111, 3'b010, 4'b1111);
        chk("t3_bcast_v", 64'(mst_ac_valid_o), 64'b1111);
        chk("t3_addr", mst_ac_addr_o, 64'hDEAD_BEEF_0000_1240);
        chk("t3_snoop_prot", 64'({mst_ac_snoop_o, mst_ac_prot_o}),
            64'({4'b0111, 3'b010}));
        wait_cr(0);
        chk("t3_resp", 64'(up_cr), 64'b01101);
        wait_data(4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_data%0d", k), up_data[k], 64'hB300 + 64'(k));
        end
        chk("t3_last", 64'(up_last[3:0]), 64'b1000);
        chk("t3_drain_beats", 64'(m_beat[1]), 64'd4);
        chk("t3_drain_done", 64'(cd_pend[1]), 64'd0);

        // Error merge with throttled upstream CD.
        setm(0, 0, 5'b00011, 3, 64'hC000);
        setm(1, 0, 5'b00000, 0, 64'h0);
        setm(3, 0, 5'b00000, 0, 64'h0);
        cfg_cd_tog = 1'b1;
        clr();
        send_ac(64'h3000, 4'h0, 3'h0, 4'b0011);
        wait_cr(0);
        chk("t4_resp", 64'(up_cr), 64'b00011);
        wait_data(3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_data%0d", k), up_data[k], 64'hC000 + 64'(k));
        end
        chk("t4_last", 64'(up_last[2:0]), 64'b100);
        cfg_cd_tog = 1'b0;

        // Best-case latency, then a second AC held valid meanwhile.
        setm(0, 0, 5'b00000, 0, 64'h0);
        clr();
        ac_addr_i     = 64'h5000;
        domain_mask_i = 4'b0001;
        ac_valid_i    = 1'b1;
        n = 0;
        while (!ac_ready_o && n < 50) begin
            tick();
            n++;
        end
        tick();
        ac_addr_i = 64'h6000;
        n = 0;
        while (!ac_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("t5_latency", 64'(n), 64'd3);
        chk("t5_first_done", 64'(up_cr_n), 64'd1);
        tick();
        ac_valid_i = 1'b0;
        chk("t5_addr2", mst_ac_addr_o, 64'h6000);
        wait_cr(1);
        chk("t5_ac_cnt", 64'(ac_cnt[0]), 64'd2);

        // Reset during DATA after two beats.
        setm(2, 0, 5'b00001, 4, 64'hD000);
        clr();
        send_ac(64'h7000, 4'h3, 3'h2, 4'b0100);
        wait_cr(0);
        n = 0;
        while (up_n < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_two_beats", 64'(up_n), 64'd2);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("t6_rst_valids", 64'({cr_valid_o, cd_valid_o, mst_ac_valid_o,
                                  mst_cr_ready_o, mst_cd_ready_o}), 64'd0);
        chk("t6_rst_addr", mst_ac_addr_o, 64'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        chk("t6_no_more_cd", 64'(up_n), 64'd2);
        chk("t6_no_more_cr", 64'(up_cr_n), 64'd1);
        setm(2, 0, 5'b00000, 0, 64'h0);
        setm(0, 0, 5'b00001, 2, 64'hE000);
        clr();
        send_ac(64'h8000, 4'h1, 3'h0, 4'b0001);
        wait_cr(0);
        chk("t6_resp", 64'(up_cr), 64'b00001);
        wait_data(2);
        chk("t6_data0", up_data[0], 64'hE000);
        chk("t6_data1", up_data[1], 64'hE001);
        chk("t6_last", 64'(up_last[1:0]), 64'b10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
